// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: byte-source requests plus the UA_Transmitter handshake.
interface uart_tx_sched_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        tx_enable;
  logic        tx_din_rdy;
  logic [7:0]  tx_din_byte;
  logic        uart_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_drop;
  modport master(output req, req_data, uart_ready,
                 input req_ack, tx_enable, tx_din_rdy, tx_din_byte, grant_id, busy, err_drop);
  modport slave(input req, req_data, uart_ready,
                output req_ack, tx_enable, tx_din_rdy, tx_din_byte, grant_id, busy, err_drop);
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin share of one UA_Transmitter among four byte sources,
// with the baud-tick divider driving the transmitter enable.
module uart_tx_sched #(
  parameter int BAUD_DIV = 434,
  parameter int BUSY_TMO = 4
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, tmo_q, tmo_d;
  logic [1:0]  ptr_q, ptr_d, grant_q, grant_d, win, idx;
  logic [3:0]  ack_q, ack_d;
  logic [7:0]  dbyte_q, dbyte_d;
  logic        rdy_q, rdy_d, busy_q, busy_d, err_q, err_d, found, tick;
  assign tick = cnt_q == 16'(BAUD_DIV - 1);
  // first requester after the last winner, wrapping back to the last winner itself
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 16'd1;
    state_d = state_q;
    tmo_d   = tmo_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    dbyte_d = dbyte_q;
    ack_d   = '0;
    rdy_d   = rdy_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (found && bus.uart_ready) begin
        dbyte_d = bus.req_data[{win, 3'b000} +: 8];
        grant_d = win;
        ptr_d   = win;
        ack_d   = 4'b0001 << win;
        rdy_d   = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (tick) begin
        rdy_d   = 1'b0;
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (!bus.uart_ready) state_d = WAIT_DONE;
        else if (tick) begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_q == 16'(BUSY_TMO - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      WAIT_DONE: state_d = bus.uart_ready ? IDLE : WAIT_DONE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ptr_q   <= 2'd3;
      grant_q <= '0;
      dbyte_q <= '0;
      ack_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dbyte_q <= dbyte_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  assign bus.tx_enable   = tick;
  assign bus.tx_din_rdy  = rdy_q;
  assign bus.tx_din_byte = dbyte_q;
  assign bus.req_ack     = ack_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.err_drop    = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios against uart_tx_sched with a simple
// transmitter model that latches on din_rdy && enable and shifts a 10-bit frame.
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_sched_if bus();
  uart_tx_sched #(.BAUD_DIV(4), .BUSY_TMO(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vec = 0;
  int miss = 0;
  logic model_on = 1'b1;
  logic ur, shifting;
  logic [9:0] frame, rx;
  logic [3:0] nb;
  logic [7:0] dec_q[$];
  assign bus.uart_ready = ur;
  // transmitter model: start bit, 8 data bits LSB first, stop bit, one per enable tick
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ur <= 1'b1;
      shifting <= 1'b0;
      nb <= '0;
      frame <= '0;
      rx <= '0;
    end else if (model_on) begin
      if (!shifting && bus.tx_din_rdy && bus.tx_enable) begin
        frame <= {1'b1, bus.tx_din_byte, 1'b0};
        shifting <= 1'b1;
        nb <= '0;
        ur <= 1'b0;
      end else if (shifting && bus.tx_enable) begin
        if (nb == 4'd10) begin
          shifting <= 1'b0;
          ur <= 1'b1;
          dec_q.push_back(rx[8:1]);
        end else begin
          rx <= {frame[0], rx[9:1]};
          frame <= frame >> 1;
          nb <= nb + 4'd1;
        end
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.req_ack != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset;
    logic [22:0] outs;
    rst_n = 1'b0;
    #12;
    outs = {bus.req_ack, bus.tx_din_rdy, bus.tx_din_byte, bus.grant_id, bus.busy, bus.err_drop, bus.tx_enable, bus.uart_ready ^ 1'b1, 3'b000};
    vec++;
    if (outs !== 23'd0) begin miss++; $display("FAIL reset_outs: got %h want 0", outs); end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      vec++;
      if (bus.tx_enable !== ((c % 4) == 3)) begin
        miss++; $display("FAIL baud_tick c=%0d: got %b want %b", c, bus.tx_enable, (c % 4) == 3);
      end
      outs = {bus.req_ack, bus.tx_din_rdy, bus.tx_din_byte, bus.grant_id, bus.busy, bus.err_drop, 5'b0};
      vec++;
      if (outs !== 23'd0) begin miss++; $display("FAIL idle_outs c=%0d: got %h want 0", c, outs); end
    end
  endtask
  task automatic test_single;
    logic ok, prev, fell, early;
    dec_q.delete();
    bus.req_data = 32'h00A5_0000;
    bus.req = 4'b0100;
    wait_ack(ok);
    vec++; if (!ok) begin miss++; $display("FAIL single_ack_timeout: got no ack want ack"); end
    vec++; if (bus.req_ack !== 4'b0100) begin miss++; $display("FAIL single_ack: got %b want 0100", bus.req_ack); end
    vec++; if (bus.grant_id !== 2'd2) begin miss++; $display("FAIL single_grant: got %0d want 2", bus.grant_id); end
    vec++; if (bus.tx_din_byte !== 8'hA5) begin miss++; $display("FAIL single_byte: got %h want a5", bus.tx_din_byte); end
    vec++; if (bus.tx_din_rdy !== 1'b1) begin miss++; $display("FAIL single_rdy: got %b want 1", bus.tx_din_rdy); end
    bus.req = 4'b0;
    prev = bus.tx_enable;
    tick();
    vec++; if (bus.req_ack !== 4'b0) begin miss++; $display("FAIL single_ack_pulse: got %b want 0000", bus.req_ack); end
    fell = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.tx_din_rdy) begin fell = 1'b1; break; end
      prev = bus.tx_enable;
      tick();
    end
    vec++; if (!(fell && prev)) begin miss++; $display("FAIL rdy_drop_on_tick: got fell=%b tick=%b want 1 1", fell, prev); end
    early = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ur) break;
      if (!bus.busy) early = 1'b1;
      tick();
    end
    vec++; if (early || !ur) begin miss++; $display("FAIL busy_span: got early=%b ready=%b want 0 1", early, ur); end
    vec++; if (bus.busy !== 1'b1) begin miss++; $display("FAIL busy_at_ready: got %b want 1", bus.busy); end
    tick();
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL busy_after_done: got %b want 0", bus.busy); end
    vec++; if (dec_q.size() != 1 || dec_q[0] !== 8'hA5) begin miss++; $display("FAIL serial_a5: got n=%0d want a5", dec_q.size()); end
  endtask
  task automatic test_rr;
    logic ok;
    logic [3:0] e;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    dec_q.delete();
    bus.req_data = 32'h4433_2211;
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(ok);
      e = 4'b0001 << order[n];
      vec++;
      if (!ok || bus.req_ack !== e) begin miss++; $display("FAIL rr_ack%0d: got %b want %b", n, bus.req_ack, e); end
    end
    bus.req = 4'b0;
    wait_idle(ok);
    vec++; if (!ok || dec_q.size() != 5) begin miss++; $display("FAIL rr_count: got %0d want 5", dec_q.size()); end
    for (int n = 0; n < 5; n++) begin
      vec++;
      if (n >= dec_q.size() || dec_q[n] !== exp_b[n]) begin miss++; $display("FAIL rr_serial%0d: got %h want %h", n, (n < dec_q.size()) ? dec_q[n] : 8'hxx, exp_b[n]); end
    end
  endtask
  task automatic test_wrap;
    logic ok;
    bus.req_data = 32'h0000_BB00;
    bus.req = 4'b0010;
    wait_ack(ok);
    vec++; if (!ok || bus.req_ack !== 4'b0010) begin miss++; $display("FAIL wrap_first: got %b want 0010", bus.req_ack); end
    bus.req = 4'b0;
    wait_idle(ok);
    tick();
    bus.req_data = 32'h0000_CCDD;
    bus.req = 4'b0011;
    wait_ack(ok);
    vec++; if (!ok || bus.req_ack !== 4'b0001) begin miss++; $display("FAIL wrap_ack: got %b want 0001", bus.req_ack); end
    vec++; if (bus.grant_id !== 2'd0) begin miss++; $display("FAIL wrap_grant: got %0d want 0", bus.grant_id); end
    vec++; if (bus.tx_din_byte !== 8'hDD) begin miss++; $display("FAIL wrap_byte: got %h want dd", bus.tx_din_byte); end
    bus.req = 4'b0;
    wait_idle(ok);
  endtask
  task automatic test_timeout;
    logic ok, seen;
    int extra;
    dec_q.delete();
    tick();
    model_on = 1'b0;
    bus.req_data = 32'h5A00_0000;
    bus.req = 4'b1000;
    wait_ack(ok);
    vec++; if (!ok || bus.req_ack !== 4'b1000) begin miss++; $display("FAIL tmo_ack: got %b want 1000", bus.req_ack); end
    bus.req = 4'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.err_drop) begin seen = 1'b1; break; end
    end
    vec++; if (!seen) begin miss++; $display("FAIL tmo_err: got 0 want 1"); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL tmo_idle: got busy=%b want 0", bus.busy); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.err_drop) extra++;
    end
    vec++; if (extra != 0) begin miss++; $display("FAIL tmo_pulse: got %0d extra pulses want 0", extra); end
    model_on = 1'b1;
    bus.req_data = 32'h0000_00C3;
    bus.req = 4'b0001;
    wait_ack(ok);
    vec++; if (!ok || bus.req_ack !== 4'b0001 || bus.grant_id !== 2'd0) begin miss++; $display("FAIL tmo_regrant: got ack=%b id=%0d want 0001 0", bus.req_ack, bus.grant_id); end
    bus.req = 4'b0;
    wait_idle(ok);
    vec++; if (dec_q.size() != 1 || dec_q[0] !== 8'hC3) begin miss++; $display("FAIL tmo_serial: got n=%0d want c3 only", dec_q.size()); end
  endtask
  task automatic test_reset_mid;
    logic ok;
    logic [14:0] outs;
    bus.req_data = 32'h0066_0000;
    bus.req = 4'b0100;
    wait_ack(ok);
    bus.req = 4'b0;
    for (int i = 0; i < 50; i++) begin
      if (!ur) break;
      tick();
    end
    tick();
    tick();
    vec++; if (ur !== 1'b0 || bus.busy !== 1'b1) begin miss++; $display("FAIL mid_in_done: got ready=%b busy=%b want 0 1", ur, bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.req_ack, bus.tx_din_rdy, bus.tx_din_byte, bus.busy, bus.err_drop};
    vec++; if (outs !== 15'd0 || bus.grant_id !== 2'd0) begin miss++; $display("FAIL mid_async_reset: got %h id=%0d want 0 0", outs, bus.grant_id); end
    @(negedge clk) rst_n = 1'b1;
    bus.req_data = 32'h8800_0077;
    bus.req = 4'b1001;
    wait_ack(ok);
    vec++; if (!ok || bus.req_ack !== 4'b0001) begin miss++; $display("FAIL mid_ack: got %b want 0001", bus.req_ack); end
    vec++; if (bus.grant_id !== 2'd0 || bus.tx_din_byte !== 8'h77) begin miss++; $display("FAIL mid_grant: got id=%0d byte=%h want 0 77", bus.grant_id, bus.tx_din_byte); end
    bus.req = 4'b0;
    wait_idle(ok);
  endtask
  initial begin
    bus.req = 4'b0;
    bus.req_data = 32'b0;
    test_reset();
    test_single();
    test_rr();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
